// File: rtl/phase_increment_sweeper.sv
// phase_increment_sweeper: steps a DDS tuning word from f_start to f_stop
// in f_step increments, holding each value for dwell_cycles+1 sample-clock
// enables. Optional triangle (up/down) sweeping is compiled in only when the
// macro PHASE_SWEEP_TRIANGLE_EN is defined; otherwise every sweep is a
// single up-sweep and the mode port is ignored.
module phase_increment_sweeper #(
  parameter int PHASE_WIDTH = 64,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          sample_clk_ce,
  input  logic                          start,
  input  logic                          abort,
  input  logic        [PHASE_WIDTH-1:0] f_start,
  input  logic        [PHASE_WIDTH-1:0] f_stop,
  input  logic        [PHASE_WIDTH-1:0] f_step,
  input  logic        [DWELL_WIDTH-1:0] dwell_cycles,
  input  logic                          mode,
  output logic signed [PHASE_WIDTH-1:0] phase_increment,
  output logic                          busy,
  output logic                          sweep_done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                 state_reg;
  logic [PHASE_WIDTH-1:0] phase_reg;
  logic [PHASE_WIDTH-1:0] f_stop_reg;
  logic [PHASE_WIDTH-1:0] f_step_reg;
  logic [DWELL_WIDTH-1:0] dwell_reg;
  logic [DWELL_WIDTH-1:0] cnt_reg;
  logic                   busy_reg;
  logic                   done_reg;

  // Up-step is one bit wider so a wrap past 2^PHASE_WIDTH still clamps.
  logic [PHASE_WIDTH:0]   up_sum;
  logic                   up_hit;
  logic                   step_now;
  logic                   dir_down;
  logic                   triangle_mode;

  assign up_sum   = {1'b0, phase_reg} + {1'b0, f_step_reg};
  assign up_hit   = (up_sum >= {1'b0, f_stop_reg});
  assign step_now = sample_clk_ce && (cnt_reg == dwell_reg);

`ifdef PHASE_SWEEP_TRIANGLE_EN
  logic [PHASE_WIDTH-1:0] f_start_reg;
  logic                   mode_reg;
  logic                   dir_reg;      // 1 = stepping down
  logic [PHASE_WIDTH:0]   dn_diff;
  logic                   dn_hit;

  // Borrow out of the wide subtraction means the step went below zero.
  assign dn_diff       = {1'b0, phase_reg} - {1'b0, f_step_reg};
  assign dn_hit        = dn_diff[PHASE_WIDTH] || (dn_diff[PHASE_WIDTH-1:0] <= f_start_reg);
  assign dir_down      = dir_reg;
  assign triangle_mode = mode_reg;
`else
  logic mode_unused;
  assign mode_unused   = mode;
  assign dir_down      = 1'b0;
  assign triangle_mode = 1'b0;
`endif

  // Sweep controller: reset, then abort, then start/stepping priority.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_reg  <= IDLE;
      phase_reg  <= '0;
      f_stop_reg <= '0;
      f_step_reg <= '0;
      dwell_reg  <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef PHASE_SWEEP_TRIANGLE_EN
      f_start_reg <= '0;
      mode_reg    <= 1'b0;
      dir_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            f_stop_reg <= f_stop;
            f_step_reg <= f_step;
            dwell_reg  <= dwell_cycles;
            phase_reg  <= f_start;
            cnt_reg    <= '0;
`ifdef PHASE_SWEEP_TRIANGLE_EN
            f_start_reg <= f_start;
            mode_reg    <= mode;
            dir_reg     <= 1'b0;
`endif
            if (f_stop < f_start) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= DWELL;
              busy_reg  <= 1'b1;
            end
          end
        end
        DWELL: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (sample_clk_ce) begin
            if (!step_now) begin
              cnt_reg <= cnt_reg + 1'b1;
            end else begin
              cnt_reg <= '0;
              if (dir_down) begin
`ifdef PHASE_SWEEP_TRIANGLE_EN
                if (dn_hit) begin
                  phase_reg <= f_start_reg;
                  dir_reg   <= 1'b0;
                end else begin
                  phase_reg <= dn_diff[PHASE_WIDTH-1:0];
                end
`endif
              end else if (up_hit) begin
                phase_reg <= f_stop_reg;
                if (triangle_mode) begin
`ifdef PHASE_SWEEP_TRIANGLE_EN
                  dir_reg <= 1'b1;
`endif
                end else begin
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                end
              end else begin
                phase_reg <= up_sum[PHASE_WIDTH-1:0];
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign phase_increment = phase_reg;
  assign busy            = busy_reg;
  assign sweep_done      = done_reg;

endmodule
